controlunit_gen2: RTL and testbench

- Parametrised second-generation control unit for the simple CPU datapath.
- Holds the program counter, instruction register and sequencing FSM, and drives register-file, ALU and data-memory controls.
- Adds over the first generation:
  - variable-latency instruction and data memory via ack handshakes;
  - signed PC-relative branches;
  - JNZ, JMP and HALT/resume;
  - illegal-opcode flagging.

---
 rtl/controlunit_gen2_if.sv | 39 +++
 rtl/controlunit_gen2.sv | 166 ++++++++++++++++
 tb/tb_controlunit_gen2.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/controlunit_gen2_if.sv
// Bus bundle between the control unit and its memories/register file/ALU.
// master = control unit side, slave = datapath/memory side.
interface controlunit_gen2_if #(
  parameter int PC_W  = 16,
  parameter int D_AW  = 8,
  parameter int RF_DW = 8
);
  logic [15:0]      inst;
  logic             I_ack;
  logic             D_ack;
  logic             RF_Rp_zero;
  logic             resume;
  logic [PC_W-1:0]  progcntr;
  logic             fetch;
  logic [D_AW-1:0]  D_addr;
  logic             D_rd;
  logic             D_wr;
  logic [RF_DW-1:0] RF_W_data;
  logic             RF_s1, RF_s0;
  logic [3:0]       RF_W_addr, RF_Rp_addr, RF_Rq_addr;
  logic             RF_W_wr, RF_Rp_rd, RF_Rq_rd;
  logic             alu_s1, alu_s0;
  logic             halted;
  logic             illegal;

  modport master (
    input  inst, I_ack, D_ack, RF_Rp_zero, resume,
    output progcntr, fetch, D_addr, D_rd, D_wr, RF_W_data, RF_s1, RF_s0,
           RF_W_addr, RF_Rp_addr, RF_Rq_addr, RF_W_wr, RF_Rp_rd, RF_Rq_rd,
           alu_s1, alu_s0, halted, illegal
  );

  modport slave (
    output inst, I_ack, D_ack, RF_Rp_zero, resume,
    input  progcntr, fetch, D_addr, D_rd, D_wr, RF_W_data, RF_s1, RF_s0,
           RF_W_addr, RF_Rp_addr, RF_Rq_addr, RF_W_wr, RF_Rp_rd, RF_Rq_rd,
           alu_s1, alu_s0, halted, illegal
  );
endinterface

// File: rtl/controlunit_gen2.sv
// Second-generation CPU control unit: PC, IR and sequencing FSM with ack-based
// memory handshakes, signed PC-relative branches, HALT/resume and illegal-op flag.
module controlunit_gen2 #(
  parameter int          PC_W     = 16,
  parameter int          D_AW     = 8,
  parameter int          RF_DW    = 8,
  parameter int unsigned RESET_PC = 0
) (
  input logic                clk,
  input logic                rst,
  controlunit_gen2_if.master cu
);
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_LOAD    = 4'd2;
  localparam logic [3:0] S_STORE   = 4'd3;
  localparam logic [3:0] S_ADD     = 4'd4;
  localparam logic [3:0] S_SUB     = 4'd5;
  localparam logic [3:0] S_LDC     = 4'd6;
  localparam logic [3:0] S_BR_TEST = 4'd7;
  localparam logic [3:0] S_BR_TAKE = 4'd8;
  localparam logic [3:0] S_HALT    = 4'd9;

  logic [3:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic            r_illegal;

  logic [3:0]      w_op, w_ra, w_rb, w_rc;
  logic [7:0]      w_imm;
  logic [PC_W-1:0] w_off;
  logic            w_take;

  assign w_op  = r_ir[15:12];
  assign w_ra  = r_ir[11:8];
  assign w_rb  = r_ir[7:4];
  assign w_rc  = r_ir[3:0];
  assign w_imm = r_ir[7:0];
  assign w_off = PC_W'(signed'(w_imm));
  assign w_take = ((w_op == 4'h5) &&  cu.RF_Rp_zero) ||
                  ((w_op == 4'h6) && !cu.RF_Rp_zero);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_pc      <= PC_W'(RESET_PC);
      r_ir      <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: if (cu.I_ack) begin
          r_ir    <= cu.inst;
          r_pc    <= r_pc + PC_W'(1);
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (w_op)
            4'h0:       r_state <= S_LOAD;
            4'h1:       r_state <= S_STORE;
            4'h2:       r_state <= S_ADD;
            4'h3:       r_state <= S_LDC;
            4'h4:       r_state <= S_SUB;
            4'h5, 4'h6: r_state <= S_BR_TEST;
            4'h7:       r_state <= S_BR_TAKE;
            4'hF:       r_state <= S_HALT;
            default: begin
              r_illegal <= 1'b1;
              r_state   <= S_FETCH;
            end
          endcase
        end
        S_LOAD, S_STORE: if (cu.D_ack) r_state <= S_FETCH;
        S_BR_TEST: r_state <= w_take ? S_BR_TAKE : S_FETCH;
        // PC already points past the branch, so the -1 makes the offset relative to the branch itself
        S_BR_TAKE: begin
          r_pc    <= r_pc + w_off - PC_W'(1);
          r_state <= S_FETCH;
        end
        S_HALT: if (cu.resume) r_state <= S_FETCH;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  logic             w_fetch, w_d_rd, w_d_wr, w_w_wr, w_p_rd, w_q_rd, w_halted;
  logic [D_AW-1:0]  w_d_addr;
  logic [RF_DW-1:0] w_w_data;
  logic [1:0]       w_rf_s, w_alu;
  logic [3:0]       w_w_addr, w_p_addr, w_q_addr;

  // Outputs are forced quiet while reset is held, independent of the clock.
  always_comb begin
    w_fetch  = 1'b0;
    w_d_rd   = 1'b0;
    w_d_wr   = 1'b0;
    w_d_addr = '0;
    w_w_data = '0;
    w_rf_s   = 2'b00;
    w_alu    = 2'b00;
    w_w_addr = '0;
    w_p_addr = '0;
    w_q_addr = '0;
    w_w_wr   = 1'b0;
    w_p_rd   = 1'b0;
    w_q_rd   = 1'b0;
    w_halted = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: w_fetch = 1'b1;
        S_LOAD: begin
          w_d_rd   = 1'b1;
          w_d_addr = w_imm[D_AW-1:0];
          w_rf_s   = 2'b01;
          w_w_addr = w_ra;
          w_w_wr   = cu.D_ack;
        end
        S_STORE: begin
          w_d_wr   = 1'b1;
          w_d_addr = w_imm[D_AW-1:0];
          w_p_addr = w_ra;
          w_p_rd   = 1'b1;
        end
        S_ADD, S_SUB: begin
          w_p_addr = w_rb;
          w_q_addr = w_rc;
          w_p_rd   = 1'b1;
          w_q_rd   = 1'b1;
          w_alu    = (r_state == S_ADD) ? 2'b01 : 2'b10;
          w_w_addr = w_ra;
          w_w_wr   = 1'b1;
        end
        S_LDC: begin
          w_w_data = RF_DW'(signed'(w_imm));
          w_rf_s   = 2'b10;
          w_w_addr = w_ra;
          w_w_wr   = 1'b1;
        end
        S_BR_TEST: begin
          w_p_addr = w_ra;
          w_p_rd   = 1'b1;
        end
        S_HALT: w_halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign cu.progcntr   = r_pc;
  assign cu.illegal    = r_illegal;
  assign cu.fetch      = w_fetch;
  assign cu.D_rd       = w_d_rd;
  assign cu.D_wr       = w_d_wr;
  assign cu.D_addr     = w_d_addr;
  assign cu.RF_W_data  = w_w_data;
  assign cu.RF_s1      = w_rf_s[1];
  assign cu.RF_s0      = w_rf_s[0];
  assign cu.alu_s1     = w_alu[1];
  assign cu.alu_s0     = w_alu[0];
  assign cu.RF_W_addr  = w_w_addr;
  assign cu.RF_Rp_addr = w_p_addr;
  assign cu.RF_Rq_addr = w_q_addr;
  assign cu.RF_W_wr    = w_w_wr;
  assign cu.RF_Rp_rd   = w_p_rd;
  assign cu.RF_Rq_rd   = w_q_rd;
  assign cu.halted     = w_halted;
endmodule

// File: tb/tb_controlunit_gen2.sv
// Bench for controlunit_gen2: instruction-level model predicts the output
// vector of every cycle; directed literal checks pin the model's key results.
module tb_controlunit_gen2;
  localparam int          PC_W   = 16;
  localparam int          D_AW   = 8;
  localparam int          RF_DW  = 16;
  localparam logic [15:0] RST_PC = 16'h0010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controlunit_gen2_if #(.PC_W(PC_W), .D_AW(D_AW), .RF_DW(RF_DW)) cu ();
  controlunit_gen2 #(.PC_W(PC_W), .D_AW(D_AW), .RF_DW(RF_DW), .RESET_PC(32'h0010))
    dut (.clk(clk), .rst(rst), .cu(cu));

  typedef struct packed {
    logic [15:0] pc;
    logic        fetch, d_rd, d_wr;
    logic [7:0]  d_addr;
    logic [15:0] wdata;
    logic [1:0]  rfs;
    logic [3:0]  waddr, paddr, qaddr;
    logic        wwr, prd, qrd;
    logic [1:0]  alu;
    logic        halted, illegal;
  } obs_t;

  obs_t exp_o, dut_o;
  bit   chk = 1'b0;
  int   n_vec = 0, n_err = 0;
  int   rd_cnt = 0, wr_cnt = 0;
  logic [15:0] last_wdata;
  logic [3:0]  last_waddr;
  logic [1:0]  last_rfs;
  logic [15:0] m_pc;
  bit          m_ill;

  assign dut_o = {cu.progcntr, cu.fetch, cu.D_rd, cu.D_wr, cu.D_addr, cu.RF_W_data,
                  cu.RF_s1, cu.RF_s0, cu.RF_W_addr, cu.RF_Rp_addr, cu.RF_Rq_addr,
                  cu.RF_W_wr, cu.RF_Rp_rd, cu.RF_Rq_rd, cu.alu_s1, cu.alu_s0,
                  cu.halted, cu.illegal};

  always @(negedge clk) begin
    if (chk) begin
      n_vec++;
      if (dut_o !== exp_o) begin
        n_err++;
        $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, dut_o, exp_o);
      end
      if (cu.D_rd) rd_cnt++;
      if (cu.RF_W_wr) begin
        wr_cnt++;
        last_wdata = cu.RF_W_data;
        last_waddr = cu.RF_W_addr;
        last_rfs   = {cu.RF_s1, cu.RF_s0};
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic obs_t base();
    obs_t b;
    b = '0;
    b.pc = m_pc;
    b.illegal = m_ill;
    return b;
  endfunction

  task automatic drv(input bit ia, input logic [15:0] in, input bit da, input bit z, input bit rs);
    cu.I_ack = ia; cu.inst = in; cu.D_ack = da; cu.RF_Rp_zero = z; cu.resume = rs;
  endtask

  task automatic tick(input obs_t e);
    exp_o = e;
    chk = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One instruction end to end: iw/dw = wait cycles before I_ack/D_ack,
  // z = Rp-zero value at the test, hc = halt cycles before resume.
  task automatic run_inst(input logic [15:0] ins, input int iw, input int dw,
                          input bit z, input int hc);
    obs_t e;
    logic [15:0] at, off;
    logic [3:0]  op, ra, rb_, rc;
    at = m_pc; op = ins[15:12]; ra = ins[11:8]; rb_ = ins[7:4]; rc = ins[3:0];
    off = {{8{ins[7]}}, ins[7:0]};
    for (int k = 0; k <= iw; k++) begin
      e = base(); e.fetch = 1'b1;
      drv(k == iw, (k == iw) ? ins : 16'($urandom), rb(), rb(), rb());
      tick(e);
    end
    m_pc = at + 16'd1;
    e = base(); drv(rb(), 16'($urandom), rb(), rb(), rb()); tick(e);
    case (op)
      4'h0, 4'h1: for (int k = 0; k <= dw; k++) begin
        e = base(); e.d_addr = ins[7:0];
        if (op == 4'h0) begin
          e.d_rd = 1'b1; e.rfs = 2'b01; e.waddr = ra; e.wwr = (k == dw);
        end else begin
          e.d_wr = 1'b1; e.paddr = ra; e.prd = 1'b1;
        end
        drv(rb(), 16'($urandom), k == dw, rb(), rb());
        tick(e);
      end
      4'h2, 4'h4: begin
        e = base(); e.paddr = rb_; e.qaddr = rc; e.prd = 1'b1; e.qrd = 1'b1;
        e.alu = (op == 4'h2) ? 2'b01 : 2'b10; e.waddr = ra; e.wwr = 1'b1;
        drv(rb(), 16'($urandom), rb(), rb(), rb()); tick(e);
      end
      4'h3: begin
        e = base(); e.wdata = off; e.rfs = 2'b10; e.waddr = ra; e.wwr = 1'b1;
        drv(rb(), 16'($urandom), rb(), rb(), rb()); tick(e);
      end
      4'h5, 4'h6, 4'h7: begin
        if (op != 4'h7) begin
          e = base(); e.paddr = ra; e.prd = 1'b1;
          drv(rb(), 16'($urandom), rb(), z, rb()); tick(e);
        end
        if (op == 4'h7 || ((op == 4'h5) == z)) begin
          e = base(); drv(rb(), 16'($urandom), rb(), rb(), rb()); tick(e);
          m_pc = at + off;
        end
      end
      4'hF: for (int k = 0; k <= hc; k++) begin
        e = base(); e.halted = 1'b1;
        drv(rb(), 16'($urandom), rb(), rb(), k == hc);
        tick(e);
      end
      default: m_ill = 1'b1;
    endcase
  endtask

  task automatic do_reset();
    chk = 1'b0;
    rst = 1'b0;
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    m_pc = RST_PC;
    m_ill = 1'b0;
  endtask

  initial begin
    obs_t e;
    int s_rd, s_wr;
    logic [15:0] p;
    rst = 1'b0;
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    lit("reset_fetch", 32'(cu.fetch), 32'd0);
    lit("reset_pc", 32'(cu.progcntr), 32'h0010);
    lit("reset_illegal", 32'(cu.illegal), 32'd0);
    rst = 1'b1; m_pc = RST_PC; m_ill = 1'b0;

    run_inst(16'h53FC, 0, 0, 1'b1, 0);
    lit("jz_taken_pc", 32'(cu.progcntr), 32'h000C);
    do_reset();
    run_inst(16'h63FC, 0, 0, 1'b1, 0);
    lit("jnz_not_taken_pc", 32'(cu.progcntr), 32'h0011);
    do_reset();
    run_inst(16'h70EE, 0, 0, 1'b0, 0);
    lit("jmp_back_pc", 32'(cu.progcntr), 32'hFFFE);
    run_inst(16'h7005, 1, 0, 1'b0, 0);
    lit("jmp_wrap_pc", 32'(cu.progcntr), 32'h0003);

    run_inst(16'h3A85, 0, 0, 1'b0, 0);
    lit("ldc_data", 32'(last_wdata), 32'hFF85);
    lit("ldc_waddr", 32'(last_waddr), 32'hA);
    lit("ldc_rfs", 32'(last_rfs), 32'd2);

    s_rd = rd_cnt; s_wr = wr_cnt;
    run_inst(16'h0212, 0, 3, 1'b0, 0);
    lit("load_rd_cycles", 32'(rd_cnt - s_rd), 32'd4);
    lit("load_wr_pulses", 32'(wr_cnt - s_wr), 32'd1);

    p = cu.progcntr;
    run_inst(16'hF000, 0, 0, 1'b0, 10);
    lit("halt_resume_pc", 32'(cu.progcntr), 32'(p + 16'd1));
    lit("halt_resume_fetch", 32'(cu.fetch), 32'd1);

    run_inst(16'h9000, 0, 0, 1'b0, 0);
    lit("illegal_set", 32'(cu.illegal), 32'd1);
    run_inst(16'h2123, 0, 0, 1'b0, 0);
    run_inst(16'h3000, 2, 0, 1'b0, 0);
    lit("illegal_sticky", 32'(cu.illegal), 32'd1);

    // abort a LOAD that is still waiting on D_ack
    drv(1'b1, 16'h0240, 1'b0, 1'b0, 1'b0); e = base(); e.fetch = 1'b1; tick(e);
    m_pc = m_pc + 16'd1;
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0); e = base(); tick(e);
    e = base(); e.d_rd = 1'b1; e.d_addr = 8'h40; e.rfs = 2'b01; e.waddr = 4'h2;
    tick(e); tick(e);
    chk = 1'b0;
    #2 rst = 1'b0;
    #1;
    lit("async_rst_d_rd", 32'(cu.D_rd), 32'd0);
    lit("async_rst_pc", 32'(cu.progcntr), 32'h0010);
    lit("async_rst_illegal", 32'(cu.illegal), 32'd0);
    lit("async_rst_fetch", 32'(cu.fetch), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1; m_pc = RST_PC; m_ill = 1'b0;

    for (int i = 0; i < 200; i++) begin
      logic [15:0] ins;
      int sel;
      sel = int'($urandom_range(0, 19));
      ins = 16'($urandom);
      if (sel < 16)      ins[15:12] = 4'(sel % 8);
      else if (sel < 18) ins[15:12] = 4'hF;
      else               ins[15:12] = 4'(8 + $urandom_range(0, 6));
      run_inst(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb(),
               int'($urandom_range(0, 3)));
    end
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
